// File: rtl/word_serializer.sv
// Parallel-to-serial converter: sign-extends NO_CH signed words and streams them LSD first as SER_BW-bit digits.
// Optional macro SER_LAST_EN adds a registered last_out flag marking the final digit of each word.
module word_serializer #(
   parameter int NO_CH  = 10,
   parameter int BW_IN  = 12,
   parameter int SER_BW = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           vld_in,
   output logic                           rdy_in,
   input  logic [NO_CH-1:0][BW_IN-1:0]    data_in,
   output logic                           vld_out,
   output logic [NO_CH-1:0][SER_BW-1:0]   data_out
`ifdef SER_LAST_EN
   ,
   output logic                           last_out
`endif
);

   localparam int NO_DIG    = 1 << ($clog2(BW_IN) - $clog2(SER_BW));
   localparam int PAD_BW    = NO_DIG * SER_BW;
   localparam int CNTR_SIZE = (NO_DIG > 1) ? $clog2(NO_DIG) : 1;
   localparam logic [CNTR_SIZE-1:0] LAST_DIG = CNTR_SIZE'(NO_DIG - 1);

   generate
      if ((SER_BW < 1) || ((SER_BW & (SER_BW - 1)) != 0) || (SER_BW > BW_IN)) begin : g_bad_params
         $error("word_serializer: SER_BW must be a power of two no larger than BW_IN");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   state_t                         state;
   state_t                         state_next;
   logic [CNTR_SIZE-1:0]           cntr;
   logic [CNTR_SIZE-1:0]           cntr_next;
   logic [NO_CH-1:0][PAD_BW-1:0]   sr;
   logic [NO_CH-1:0][PAD_BW-1:0]   sr_next;
   logic                           at_last;
   logic                           accept;

   // Ready is purely a function of state so the source may look at it before raising vld_in.
   assign at_last = (cntr == LAST_DIG);
   assign rdy_in  = (state == ST_IDLE) || at_last;
   assign accept  = vld_in && rdy_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cntr  <= '0;
         sr    <= '0;
      end else begin
         state <= state_next;
         cntr  <= cntr_next;
         sr    <= sr_next;
      end
   end

   // An accept on the final digit reloads directly, which keeps the digit stream gap-free across words.
   always_comb begin
      state_next = state;
      cntr_next  = cntr;
      sr_next    = sr;
      if (accept) begin
         state_next = ST_BUSY;
         cntr_next  = '0;
         for (int i = 0; i < NO_CH; i++) begin
            sr_next[i] = PAD_BW'($signed(data_in[i]));
         end
      end else if (state == ST_BUSY) begin
         if (!at_last) begin
            cntr_next = cntr + CNTR_SIZE'(1);
            for (int i = 0; i < NO_CH; i++) begin
               sr_next[i] = PAD_BW'($signed(sr[i]) >>> SER_BW);
            end
         end else begin
            state_next = ST_IDLE;
            cntr_next  = '0;
            sr_next    = '0;
         end
      end
   end

   assign vld_out = (state == ST_BUSY);

   // The register is cleared when idle, so data_out reads zero without extra gating.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < NO_CH; i++) begin
         data_out[i] = sr[i][SER_BW-1:0];
      end
   end

`ifdef SER_LAST_EN
   logic last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b0;
      end else begin
         last_q <= (state_next == ST_BUSY) && (cntr_next == LAST_DIG);
      end
   end

   assign last_out = last_q;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: a digit-stream model checked every cycle, plus literal digit sequences.
// A second instance covers the single-digit build (SER_BW == BW_IN).
module tb_word_serializer;

   localparam int NO_CH  = 2;
   localparam int BW_IN  = 12;
   localparam int SER_BW = 4;
   localparam int NO_DIG = 4;

   logic                           clk = 1'b0;
   logic                           rst = 1'b1;
   logic                           vld_in = 1'b0;
   logic                           rdy_in;
   logic [NO_CH-1:0][BW_IN-1:0]    data_in = '0;
   logic                           vld_out;
   logic [NO_CH-1:0][SER_BW-1:0]   data_out;

   logic                           vld_in1 = 1'b0;
   logic                           rdy_in1;
   logic [NO_CH-1:0][3:0]          data_in1 = '0;
   logic                           vld_out1;
   logic [NO_CH-1:0][3:0]          data_out1;

`ifdef SER_LAST_EN
   logic last_out;
   logic last_out1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   word_serializer #(.NO_CH(NO_CH), .BW_IN(BW_IN), .SER_BW(SER_BW)) dut (
      .clk      (clk),
      .rst      (rst),
      .vld_in   (vld_in),
      .rdy_in   (rdy_in),
      .data_in  (data_in),
      .vld_out  (vld_out),
      .data_out (data_out)
`ifdef SER_LAST_EN
      ,
      .last_out (last_out)
`endif
   );

   word_serializer #(.NO_CH(NO_CH), .BW_IN(4), .SER_BW(4)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .vld_in   (vld_in1),
      .rdy_in   (rdy_in1),
      .data_in  (data_in1),
      .vld_out  (vld_out1),
      .data_out (data_out1)
`ifdef SER_LAST_EN
      ,
      .last_out (last_out1)
`endif
   );

   always #5 clk = ~clk;

   // Model: remaining digits of the current word and which digit is on the output.
   int rem = 0;
   int dig = 0;
   int word [NO_CH];
   bit model_on = 1'b0;
   bit accepted = 1'b0;

   always @(posedge clk) begin
      accepted = 1'b0;
      if (rst) begin
         rem      = 0;
         dig      = 0;
         model_on = 1'b1;
      end else if (vld_in && (rem <= 1)) begin
         for (int i = 0; i < NO_CH; i++) word[i] = $signed(data_in[i]);
         rem      = NO_DIG;
         dig      = 0;
         accepted = 1'b1;
      end else if (rem > 0) begin
         rem = rem - 1;
         dig = dig + 1;
      end
   end

   function automatic logic [NO_CH*SER_BW-1:0] exp_digits();
      logic [NO_CH*SER_BW-1:0] r;
      int d;
      r = '0;
      for (int i = 0; i < NO_CH; i++) begin
         d = (rem > 0) ? ((word[i] >>> (SER_BW * dig)) & ((1 << SER_BW) - 1)) : 0;
         r[i*SER_BW +: SER_BW] = d[SER_BW-1:0];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [BW_IN-1:0] a, input logic [BW_IN-1:0] b);
      vld_in     = v;
      data_in[0] = a;
      data_in[1] = b;
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         checkOutput("m_vld_out", 32'(vld_out), 32'(rem > 0));
         checkOutput("m_data_out", 32'(data_out), 32'(exp_digits()));
         checkOutput("m_rdy_in", 32'(rdy_in), 32'(rem <= 1));
`ifdef SER_LAST_EN
         checkOutput("m_last_out", 32'(last_out), 32'(rem == 1));
`endif
         checkOutput("m_rdy_in1", 32'(rdy_in1), 32'd1);
      end
   end

   logic [3:0] s1c0 [4] = '{4'h5, 4'hA, 4'h8, 4'hF};
   logic [3:0] s1c1 [4] = '{4'h3, 4'h2, 4'h1, 4'h0};
   logic [3:0] s2c0 [8] = '{4'h5, 4'hA, 4'h8, 4'hF, 4'hF, 4'hF, 4'h7, 4'h0};
   logic       s2rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [BW_IN-1:0] stream_a [4] = '{12'hFFD, 12'h001, 12'hABC, 12'h400};
   logic [BW_IN-1:0] stream_b [4] = '{12'hFFB, 12'h800, 12'h555, 12'hBFF};

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("reset_vld", 32'(vld_out), 32'd0);
      checkOutput("reset_rdy", 32'(rdy_in), 32'd1);
      rst = 1'b0;

      $display("[TB] single word");
      applyStimulus(1'b1, 12'h8A5, 12'h123);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) applyStimulus(1'b0, '0, '0);
         checkOutput($sformatf("s1_vld_d%0d", k), 32'(vld_out), 32'd1);
         checkOutput($sformatf("s1_ch0_d%0d", k), 32'(data_out[0]), 32'(s1c0[k]));
         checkOutput($sformatf("s1_ch1_d%0d", k), 32'(data_out[1]), 32'(s1c1[k]));
      end
      @(negedge clk);
      checkOutput("s1_idle_vld", 32'(vld_out), 32'd0);
      checkOutput("s1_idle_data", 32'(data_out), 32'd0);

      $display("[TB] back-to-back words");
      applyStimulus(1'b1, 12'h8A5, 12'h123);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) applyStimulus(1'b1, 12'h7FF, 12'h800);
         if (k == 4) applyStimulus(1'b0, '0, '0);
         checkOutput($sformatf("s2_vld_%0d", k), 32'(vld_out), 32'd1);
         checkOutput($sformatf("s2_ch0_%0d", k), 32'(data_out[0]), 32'(s2c0[k]));
         checkOutput($sformatf("s2_rdy_%0d", k), 32'(rdy_in), 32'(s2rdy[k]));
`ifdef SER_LAST_EN
         checkOutput($sformatf("s2_last_%0d", k), 32'(last_out), 32'((k == 3) || (k == 7)));
`endif
      end
      @(negedge clk);
      checkOutput("s2_idle_vld", 32'(vld_out), 32'd0);

      $display("[TB] reset mid-word");
      applyStimulus(1'b1, 12'h8A5, 12'h123);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0);
      @(negedge clk);
      checkOutput("s3_d1_ch0", 32'(data_out[0]), 32'hA);
      rst = 1'b1;
      applyStimulus(1'b1, 12'h7FF, 12'h800);
      @(negedge clk);
      checkOutput("s3_rst_vld", 32'(vld_out), 32'd0);
      checkOutput("s3_rst_data", 32'(data_out), 32'd0);
      checkOutput("s3_rst_rdy", 32'(rdy_in), 32'd1);
`ifdef SER_LAST_EN
      checkOutput("s3_rst_last", 32'(last_out), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      checkOutput("s3_new_vld", 32'(vld_out), 32'd1);
      checkOutput("s3_new_ch0", 32'(data_out[0]), 32'hF);
      checkOutput("s3_new_ch1", 32'(data_out[1]), 32'h0);
      applyStimulus(1'b0, '0, '0);
      repeat (4) @(negedge clk);

      $display("[TB] single-digit build");
      vld_in1  = 1'b1;
      data_in1 = {4'h3, 4'h9};
      @(negedge clk);
      checkOutput("s5_vld_0", 32'(vld_out1), 32'd1);
      checkOutput("s5_ch0_0", 32'(data_out1[0]), 32'h9);
      checkOutput("s5_ch1_0", 32'(data_out1[1]), 32'h3);
      data_in1 = {4'h9, 4'h3};
      @(negedge clk);
      checkOutput("s5_vld_1", 32'(vld_out1), 32'd1);
      checkOutput("s5_ch0_1", 32'(data_out1[0]), 32'h3);
      checkOutput("s5_ch1_1", 32'(data_out1[1]), 32'h9);
      vld_in1 = 1'b0;
      @(negedge clk);
      checkOutput("s5_idle_vld", 32'(vld_out1), 32'd0);
      checkOutput("s5_idle_data", 32'(data_out1), 32'd0);

      $display("[TB] continuous stream");
      for (int w = 0; w < 4; w++) begin
         bit got;
         got = 1'b0;
         applyStimulus(1'b1, stream_a[w], stream_b[w]);
         for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = accepted;
         end
         if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL stream_accept_%0d: no accept within 20 cycles", w);
         end
      end
      applyStimulus(1'b0, '0, '0);
      repeat (6) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected end before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
